// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding and sizing helpers.
package serial_add_sequencer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit counter must be able to hold WIDTH after the final increment.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/structuralFullAdder.sv
// One-bit full adder built from discrete gates; reused once per clock by the serial sequencer.
module structuralFullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_axb;
    logic w_gen;
    logic w_prop;

    assign w_axb  = i_a ^ i_b;
    assign o_s    = w_axb ^ i_cin;
    assign w_gen  = i_a & i_b;
    assign w_prop = w_axb & i_cin;
    assign o_cout = w_gen | w_prop;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full adder cell walks LSB to MSB, one bit per clock,
// between a valid/ready operand handshake and a valid/ready result handshake.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned       CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_step;
    logic             w_last;

    structuralFullAdder u_cell (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The unused encoding 2'd3 falls into default and returns to idle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
            r_carry <= w_co;
            r_cnt   <= r_cnt + CNT_ONE;
            if (w_last) begin
                // r_carry still holds the carry into the MSB on this edge.
                r_cout <= w_co;
                r_ovf  <= r_carry ^ w_co;
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer at WIDTH=8: directed table, corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_serial_add_sequencer;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #200 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 100 units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #100;
    endtask

    // Reference: plain integer arithmetic, overflow when the signed result leaves the range.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, output logic [W-1:0] es,
                                  output logic ec, output logic eo);
        int unsigned u;
        int          s;
        u  = int'(ma) + int'(mb) + int'(mc);
        s  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        es = u[W-1:0];
        ec = u[W];
        eo = (s > 127) || (s < -128);
    endfunction

    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input int stall, input bit busy,
                          output logic [W-1:0] r_sum, output logic r_cout,
                          output logic r_ovf, output int lat);
        check("in_ready_idle", in_ready, 1);
        a         = op_a;
        b         = op_b;
        cin       = op_cin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 4 * W) begin
            if (busy) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = W'($urandom);
                b        = W'($urandom);
                cin      = 1'($urandom_range(0, 1));
                check("in_ready_run", in_ready, 0);
            end
            tick();
            lat++;
        end
        check("out_valid_rises", out_valid, 1);
        r_sum  = sum;
        r_cout = cout;
        r_ovf  = overflow;
        for (int k = 0; k < stall; k++) begin
            if (busy) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = W'($urandom);
                b        = W'($urandom);
            end
            tick();
            check("sum_held", sum, r_sum);
            check("out_valid_stall", out_valid, 1);
            check("in_ready_stall", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        #(100000 * 400);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[6];
        logic [W-1:0] g_sum;
        logic         g_cout;
        logic         g_ovf;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
        int           lat;

        vecs[0] = '{"basic",    8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{"wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"sovf",     8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1};
        vecs[3] = '{"negovf",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{"cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{"all_ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        #50;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        #50;
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, g_sum, g_cout, g_ovf, lat);
            check({vecs[i].name, "_lat"}, lat, W);
            check({vecs[i].name, "_sum"}, g_sum, vecs[i].sum);
            check({vecs[i].name, "_cout"}, g_cout, vecs[i].cout);
            check({vecs[i].name, "_ovf"}, g_ovf, vecs[i].ovf);
        end

        // Backpressure with operands and in_valid churning while busy.
        model(8'hA5, 8'h3C, 1'b1, e_sum, e_cout, e_ovf);
        run_op(8'hA5, 8'h3C, 1'b1, 5, 1'b1, g_sum, g_cout, g_ovf, lat);
        check("bp_lat", lat, W);
        check("bp_sum", g_sum, e_sum);
        check("bp_cout", g_cout, e_cout);
        check("bp_ovf", g_ovf, e_ovf);
        tick();
        check("bp_no_second_op", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);

        // Asynchronous reset in the fourth RUN cycle, between edges.
        a        = 8'hC3;
        b        = 8'h5A;
        cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("pre_rst_running", in_ready, 0);
        reset_n = 1'b0;
        #10;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", overflow, 0);
        #100;
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", in_ready, 1);
        check("post_rst_no_result", out_valid, 0);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, g_sum, g_cout, g_ovf, lat);
        check("post_rst_lat", lat, W);
        check("post_rst_sum", g_sum, 8'h30);
        check("post_rst_cout", g_cout, 0);
        check("post_rst_ovf", g_ovf, 0);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            int           stall;
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            model(ra, rb, rc, e_sum, e_cout, e_ovf);
            run_op(ra, rb, rc, stall, 1'($urandom_range(0, 1)), g_sum, g_cout, g_ovf, lat);
            check("rand_lat", lat, W);
            check("rand_sum", g_sum, e_sum);
            check("rand_cout", g_cout, e_cout);
            check("rand_ovf", g_ovf, e_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
